// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and active-low hex segment table for the 8-digit scanner
package disp_pkg;
  localparam int DIG_N = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Entry n is the active-low {g,f,e,d,c,b,a} pattern for hex digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/hex7seg_dec.sv
// rtl/hex7seg_dec.sv - combinational nibble to active-low seven-segment decode
module hex7seg_dec
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = HEX_SEG[nib];
  end
endmodule

// File: rtl/disp_scan_8dig.sv
// rtl/disp_scan_8dig.sv - 8-digit seven-segment scanner with frame snapshot, blink and dp
// Define DISP_LZ_BLANK_EN to blank leading zero digits.
module disp_scan_8dig
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_num,
  input  logic [7:0]  le,
  input  logic [7:0]  point,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_start
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    dig_idx_q, dig_idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [31:0]   snap_num_q, snap_num_d;
  logic [7:0]    snap_le_q, snap_le_d;
  logic [7:0]    snap_pt_q, snap_pt_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          frame_start_q, frame_start_d;

  logic [3:0]    nib;
  logic [6:0]    seg7;
  logic [7:0]    lz_mask;
  logic          scan_wrap, frame_wrap, blink_wrap;

  assign nib = snap_num_q[{dig_idx_q, 2'b00} +: 4];

  hex7seg_dec u_dec (
    .nib (nib),
    .seg (seg7)
  );

`ifdef DISP_LZ_BLANK_EN
  // A digit blanks only while every digit to its left (and itself) is a dp-less zero
  always_comb begin
    logic zero_run;
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = DIG_N - 1; i >= 1; i--) begin
      zero_run   = zero_run && (snap_num_q[4*i +: 4] == 4'h0) && !snap_pt_q[i];
      lz_mask[i] = zero_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    scan_wrap     = (scan_cnt_q == SW'(SCAN_DIV - 1));
    frame_wrap    = scan_wrap && (dig_idx_q == 3'd7);
    blink_wrap    = (blink_cnt_q == BW'(BLINK_DIV - 1));

    scan_cnt_d    = scan_wrap ? '0 : scan_cnt_q + SW'(1);
    dig_idx_d     = scan_wrap ? dig_idx_q + 3'd1 : dig_idx_q;
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    blink_on_d    = blink_wrap ? ~blink_on_q : blink_on_q;

    snap_num_d    = frame_wrap ? disp_num : snap_num_q;
    snap_le_d     = frame_wrap ? le       : snap_le_q;
    snap_pt_d     = frame_wrap ? point    : snap_pt_q;
    frame_start_d = frame_wrap;

    an_d          = ~(8'd1 << dig_idx_q);
    seg_d         = {~snap_pt_q[dig_idx_q], seg7};
    if ((snap_le_q[dig_idx_q] && !blink_on_q) || lz_mask[dig_idx_q]) begin
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt_q    <= '0;
      dig_idx_q     <= '0;
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      snap_num_q    <= '0;
      snap_le_q     <= '0;
      snap_pt_q     <= '0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      dig_idx_q     <= dig_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      snap_num_q    <= snap_num_d;
      snap_le_q     <= snap_le_d;
      snap_pt_q     <= snap_pt_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_disp_scan_8dig.sv
// tb/tb_disp_scan_8dig.sv - self-checking bench for disp_scan_8dig against a cycle-count model
module tb_disp_scan_8dig;
  localparam int S = 4;
  localparam int B = 16;
  localparam int FRAME = 8 * S;
`ifdef DISP_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] disp_num;
  logic [7:0]  le;
  logic [7:0]  point;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_start;

  int total;
  int bad;
  int n;
  logic [31:0] m_num;
  logic [7:0]  m_le;
  logic [7:0]  m_pt;
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  disp_scan_8dig #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk         (clk),
    .rst         (rst),
    .disp_num    (disp_num),
    .le          (le),
    .point       (point),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // n = clock edges since reset released; the output after an edge reflects the state before it
  task automatic tick(input string tag);
    logic [7:0] ea, es;
    logic       ef;
    int         d;
    logic       bon;
    if (!rst) begin
      ea = 8'hFF;
      es = 8'hFF;
    end else begin
      d   = (n / S) % 8;
      bon = ((n / B) % 2) == 0;
      ea  = ~(8'd1 << d);
      es  = hex_tab[m_num[4*d +: 4]];
      es[7] = ~m_pt[d];
      if (m_le[d] && !bon) es = 8'hFF;
      if (LZ && d > 0 && (m_num >> (4*d)) == 0 && (m_pt >> d) == 0) es = 8'hFF;
    end
    @(posedge clk);
    if (!rst) begin
      n = 0; m_num = '0; m_le = '0; m_pt = '0; ef = 1'b0;
    end else begin
      n++;
      ef = (n % FRAME) == 0;
      if (ef) begin
        m_num = disp_num; m_le = le; m_pt = point;
      end
    end
    @(negedge clk);
    total++;
    assert (an === ea) else begin
      bad++; $error("FAIL %s an n=%0d got=%h exp=%h", tag, n, an, ea);
    end
    total++;
    assert (seg === es) else begin
      bad++; $error("FAIL %s seg n=%0d got=%h exp=%h", tag, n, seg, es);
    end
    total++;
    assert (frame_start === ef) else begin
      bad++; $error("FAIL %s frame_start n=%0d got=%b exp=%b", tag, n, frame_start, ef);
    end
  endtask

  task automatic run(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) tick(tag);
  endtask

  task automatic run_to_digit(input string tag, input int dig);
    for (int i = 0; i < FRAME && ((n / S) % 8) != dig; i++) tick(tag);
  endtask

  initial begin
    total = 0; bad = 0; n = 0;
    m_num = '0; m_le = '0; m_pt = '0;
    rst = 1'b0; disp_num = '0; le = '0; point = '0;

    run("reset", 3);
    rst = 1'b1;
    disp_num = 32'h12345678;
    run("first_frame", FRAME);
    run("scan_order", FRAME);

    run_to_digit("coherence_pre", 3);
    disp_num = 32'hFFFFFFFF;
    run("coherence", FRAME + 8);

    point = 8'h01; le = 8'h02; disp_num = 32'h87654321;
    run("point_blink", 3 * FRAME);

    for (int k = 0; k < 60; k++) begin
      disp_num = $urandom >> $urandom_range(0, 31);
      le       = 8'($urandom);
      point    = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      run("random", $urandom_range(1, 12));
    end

    run_to_digit("mid_reset_pre", 5);
    rst = 1'b0;
    run("mid_reset", 1);
    rst = 1'b1;
    disp_num = 32'hDEADBEEF; le = 8'h00; point = 8'h00;
    run("after_reset", FRAME + 4);

    disp_num = 32'h000000A5; point = 8'h00;
    run_to_digit("lz_align", 0);
    run("lz_plain", 2 * FRAME);
    point = 8'h10;
    run("lz_point", 2 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
